// File: rtl/mac_add_relu_fp32.sv
// Binary32 neuron datapath: accumulates w*x each clock, then adds bias and applies ReLU.
// Subnormals are treated as zero and every rounding step is round-to-nearest, ties-to-even.
module mac_add_relu_fp32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] w,
    input  logic [31:0] x,
    input  logic [31:0] bias,
    output logic [31:0] acc_out,
    output logic [31:0] sum_out,
    output logic [31:0] out
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [7:0]        ea, eb;
        logic [22:0]       fa, fb;
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0]       p;
        logic signed [9:0] e;
        logic [22:0]       frac;
        logic              g, st, up;
        logic [23:0]       m;
        logic [31:0]       r;

        s      = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);

        p = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
        e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

        // Product of two [1,2) significands lies in [1,4): at most one normalizing shift.
        if (p[47]) begin
            e    = e + 10'sd1;
            frac = p[46:24];
            g    = p[23];
            st   = |p[22:0];
        end else begin
            frac = p[45:23];
            g    = p[22];
            st   = |p[21:0];
        end

        up = g & (st | frac[0]);
        m  = {1'b0, frac} + {23'd0, up};
        if (m[23])
            e = e + 10'sd1;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            r = QNAN;
        else if (a_inf || b_inf)
            r = {s, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            r = {s, 31'd0};
        else if (e >= 10'sd255)
            r = {s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            r = 32'd0;
        else
            r = {s, e[7:0], m[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big, sml;
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic              eff_sub;
        logic [7:0]        d;
        logic [5:0]        dc;
        logic [26:0]       mb_ext, ms_ext, al, n, diff;
        logic [53:0]       sh;
        logic [27:0]       sum;
        logic [4:0]        lz;
        logic signed [9:0] e;
        logic              g, st, up;
        logic [24:0]       m;
        logic [22:0]       frac;
        logic [31:0]       r;

        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);

        // Magnitude order of normals matches the unsigned order of their low 31 bits.
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        eff_sub = a[31] ^ b[31];

        d      = big[30:23] - sml[30:23];
        dc     = (d > 8'd31) ? 6'd31 : d[5:0];
        mb_ext = {1'b1, big[22:0], 3'b000};
        ms_ext = {1'b1, sml[22:0], 3'b000};
        sh     = {ms_ext, 27'd0} >> dc;
        al     = {sh[53:28], sh[27] | (|sh[26:0])};

        e    = $signed({2'b00, big[30:23]});
        sum  = {1'b0, mb_ext} + {1'b0, al};
        diff = mb_ext - al;
        lz   = 5'd0;
        n    = 27'd0;

        if (!eff_sub) begin
            if (sum[27]) begin
                n = {sum[27:2], sum[1] | sum[0]};
                e = e + 10'sd1;
            end else begin
                n = sum[26:0];
            end
        end else begin
            for (int i = 0; i < 27; i++)
                if (diff[i])
                    lz = 5'(26 - i);
            n = diff << lz;
            e = e - $signed({5'd0, lz});
        end

        g  = n[2];
        st = n[1] | n[0];
        up = g & (st | n[3]);
        m  = {1'b0, n[26:3]} + {24'd0, up};
        if (m[24]) begin
            e    = e + 10'sd1;
            frac = m[23:1];
        end else begin
            frac = m[22:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub))
            r = QNAN;
        else if (a_inf)
            r = a;
        else if (b_inf)
            r = b;
        else if (a_zero && b_zero)
            r = {a[31] & b[31], 31'd0};
        else if (a_zero)
            r = b;
        else if (b_zero)
            r = a;
        else if (eff_sub && (diff == 27'd0))
            r = 32'd0;
        else if (e >= 10'sd255)
            r = {big[31], 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            r = 32'd0;
        else
            r = {big[31], e[7:0], frac};
        return r;
    endfunction

    logic [31:0] acc;
    logic [31:0] prod;
    logic [31:0] acc_next;

    always_comb begin
        prod     = fp_mul(w, x);
        acc_next = fp_add(acc, prod);
        sum_out  = fp_add(acc, bias);
        out      = sum_out[31] ? 32'd0 : sum_out;
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc <= 32'd0;
        else
            acc <= acc_next;
    end

    assign acc_out = acc;

endmodule

// File: tb/tb_mac_add_relu_fp32.sv
// Directed bench for mac_add_relu_fp32 with hand-computed vectors and a double-precision
// reference for the rounding stream.
module tb_mac_add_relu_fp32;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] w, x, bias;
    logic [31:0] acc_out, sum_out, out;

    int checks = 0;
    int passes = 0;

    mac_add_relu_fp32 dut (
        .clk     (clk),
        .rst     (rst),
        .w       (w),
        .x       (x),
        .bias    (bias),
        .acc_out (acc_out),
        .sum_out (sum_out),
        .out     (out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference conversions: real -> binary32 with round-to-nearest-even, and back.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [31:0] f;
        logic        up;
        if (r == 0.0) return 32'd0;
        d  = $realtobits(r);
        up = d[28] && ((d[27:0] != 28'd0) || d[29]);
        f  = {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
        return f + {31'd0, up};
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    logic [31:0] ws [10];
    logic [31:0] acc_m;
    logic [31:0] out_m;
    int          dd;

    initial begin
        ws = '{32'hBF19999A, 32'h3DCCCCCD, 32'h3E4CCCCD, 32'hBE99999A, 32'h3F000000,
               32'h3F19999A, 32'h3E99999A, 32'hBE4CCCCD, 32'h3F333333, 32'h3ECCCCCD};

        rst = 1'b1; w = 32'd0; x = 32'd0; bias = 32'h3DCCCCCD;
        tick();
        rst = 1'b0;
        chk("reset_acc", acc_out, 32'h00000000);
        chk("reset_sum", sum_out, 32'h3DCCCCCD);
        chk("reset_out", out, 32'h3DCCCCCD);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_acc", acc_out, 32'h00000000);
            chk("idle_out", out, 32'h3DCCCCCD);
        end

        w = 32'h3FC00000; x = 32'h40000000;
        tick(); chk("acc_3", acc_out, 32'h40400000);
        tick(); chk("acc_6", acc_out, 32'h40C00000);
        tick(); chk("acc_9", acc_out, 32'h41100000);
        w = 32'd0; x = 32'd0; bias = 32'h3F000000; #1;
        chk("sum_9p5", sum_out, 32'h41180000);
        chk("out_9p5", out, 32'h41180000);
        bias = 32'hC1200000; #1;
        chk("relu_sum_m1", sum_out, 32'hBF800000);
        chk("relu_out_m1", out, 32'h00000000);
        bias = 32'hC1100000; #1;
        chk("cancel_sum", sum_out, 32'h00000000);
        chk("cancel_out", out, 32'h00000000);
        tick(); chk("idle_hold_9", acc_out, 32'h41100000);

        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_acc", acc_out, 32'h00000000);
        w = 32'h3F800000; x = 32'h3F000000;
        tick(); chk("mix_half", acc_out, 32'h3F000000);
        w = 32'hBF800000;
        tick(); chk("mix_zero", acc_out, 32'h00000000);

        w = 32'h3F800001; x = 32'h3F800001;
        tick(); chk("round_mul", acc_out, 32'h3F800002);

        rst = 1'b1; tick(); rst = 1'b0;
        x = 32'h3F800000; bias = 32'h3DCCCCCD;
        acc_m = 32'd0;
        for (int i = 0; i < 10; i++) begin
            w = ws[i];
            tick();
            acc_m = r2f(f2r(acc_m) + f2r(ws[i]));
            chk("stream_acc", acc_out, acc_m);
        end
        w = 32'd0; x = 32'd0; #1;
        out_m = r2f(f2r(acc_m) + f2r(32'h3DCCCCCD));
        chk("stream_out", out, out_m);
        dd = int'(out) - int'(32'h3FE66666);
        chk("stream_ulp", {31'd0, (dd >= -2) && (dd <= 2)}, 32'd1);

        rst = 1'b1; tick(); rst = 1'b0;
        w = 32'hC0000000; x = 32'h40400000; bias = 32'h3F000000;
        tick();
        chk("neg_acc", acc_out, 32'hC0C00000);
        chk("neg_sum", sum_out, 32'hC0B00000);
        chk("neg_out", out, 32'h00000000);

        rst = 1'b1; tick(); rst = 1'b0;
        w = 32'h7F000000; x = 32'h40000000;
        tick();
        chk("ovf_acc", acc_out, 32'h7F800000);
        chk("ovf_out", out, 32'h7F800000);
        w = 32'hFF800000; x = 32'h3F800000;
        tick(); chk("inf_minus_inf", acc_out, 32'h7FC00000);
        w = 32'h3F800000;
        tick(); chk("nan_sticky", acc_out, 32'h7FC00000);

        rst = 1'b1; tick(); rst = 1'b0;
        w = 32'h7F800000; x = 32'h00000000; bias = 32'h3DCCCCCD;
        tick();
        chk("inf_x_zero_acc", acc_out, 32'h7FC00000);
        chk("inf_x_zero_out", out, 32'h7FC00000);

        rst = 1'b1; tick(); rst = 1'b0;
        w = 32'h3FC00000; x = 32'h40000000;
        tick(); chk("pre_rst_acc", acc_out, 32'h40400000);
        rst = 1'b1;
        tick(); chk("mid_rst_acc", acc_out, 32'h00000000);
        rst = 1'b0; w = 32'h3F800000;
        tick(); chk("post_rst_acc", acc_out, 32'h40000000);
        w = 32'h80000000; x = 32'h3F800000;
        tick(); chk("neg_zero_idle", acc_out, 32'h40000000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mac_add_relu_fp32.md
Name: mac_add_relu_fp32

Overview:
- Single-precision (IEEE-754 binary32) neuron datapath: multiply-accumulate of weight × input, bias addition, then ReLU activation.
- One product is accumulated per clock into an internal accumulator. The bias add and ReLU are combinational on the accumulator.
- Sits below the neuron sequencer, which streams one (w, x) pair per cycle and then drives zeros while idle.

Parameters:
- none (fixed binary32 datapath, 32-bit ports)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset; clears accumulator on the next rising edge
- w  in  32  binary32 weight operand
- x  in  32  binary32 input operand
- bias  in  32  binary32 bias added after accumulation
- acc_out  out  32  accumulator value (registered), binary32
- sum_out  out  32  acc_out + bias (combinational), binary32
- out  out  32  ReLU(sum_out) (combinational), binary32

Behaviour:
- Reset: rst=1 at a rising edge sets acc to 0x00000000. rst has priority over accumulation. Asserting rst mid-stream discards the partial sum.
- After reset:
  - acc_out = 0x00000000.
  - sum_out = bias.
  - out = ReLU(bias).
- Accumulate: each rising edge with rst=0 performs acc <= acc + (w × x). Multiply and add are done combinationally in the same cycle and registered once.
- Latency:
  - A pair presented before edge k appears in acc_out after edge k.
  - sum_out and out follow acc_out combinationally in the same cycle.
- Idle: w=0 or x=0 gives a product of +0 or −0. Adding ±0 leaves acc unchanged, except that acc = −0 plus +0 becomes +0.
- Multiplier:
  - Result sign = sign(w) XOR sign(x).
  - Exponents are added and debiased (−127).
  - The 24×24 significand product (hidden 1 restored) is normalized by at most 1 bit.
- Adder (used for both acc+product and acc+bias):
  - Align the smaller-exponent operand by right shift, keeping guard/round/sticky bits.
  - Add or subtract significands by sign.
  - Renormalize with a leading-zero count; exact cancellation gives +0.
- Rounding: round-to-nearest, ties-to-even, in both multiplier and adder.
- Special cases:
  - Subnormal inputs are treated as zero.
  - Underflowing results flush to +0, sign preserved for multiplier zero.
  - Overflow gives ±Inf (0x7F800000 / 0xFF800000).
  - Any NaN operand, or Inf×0, or Inf−Inf, gives canonical NaN 0x7FC00000.
  - Inf propagates through both the multiplier and the adder.
- ReLU:
  - Sign bit 1 (negative, −0, −Inf): out = 0x00000000.
  - Sign bit 0: out = sum_out unchanged, including +Inf and canonical NaN.
- Accumulator NaN/Inf is sticky until rst.

Test Plan:
- Reset then idle: rst=1 for one edge, then w=x=0 for 5 cycles with bias=0x3DCCCCCD (0.1) -> acc_out=0x00000000 throughout, out=0x3DCCCCCD.
- Exact accumulate: w=0x3FC00000 (1.5), x=0x40000000 (2.0) for 3 edges -> acc_out 0x40400000, 0x40C00000, 0x41100000 (3, 6, 9). With bias=0x3F000000 (0.5): out=0x41180000 (9.5).
- ReLU clamp: acc=9.0 with bias=0xC1200000 (−10.0) -> sum_out=0xBF800000 (−1.0), out=0x00000000. Bias=0xC1100000 (−9.0) -> sum_out=0x00000000, out=0x00000000.
- Mixed signs / cancellation: pairs (1.0, 0.5), (−1.0, 0.5) -> acc 0x3F000000 then 0x00000000.
- Rounding: w=0x3F800001, x=0x3F800001 -> acc_out=0x3F800002. Weight stream −0.6, 0.1, 0.2, −0.3, 0.5, 0.6, 0.3, −0.2, 0.7, 0.4 with x=1.0 and bias 0.1 -> out within 2 ULP of 1.8 (0x3FE66666), bit-exact against a reference binary32 model using the same rounding.
- Specials and mid-stream reset: w=0x7F800000 with x=0 -> acc=0x7FC00000, out=0x7FC00000. Assert rst mid-stream -> acc_out=0x00000000 on the next edge; the new pair then accumulates from zero.
